// File: rtl/scr1_cg_ctrl_pkg.sv
// Shared types and constants for the SCR1 core-level clock-gating controller.
//   type_scr1_cg_state_e  : per-channel gating FSM state
//   SCR1_CG_IDLE_THR_DFLT : default idle holdoff threshold for software to load
package scr1_cg_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    GATED = 2'd1,
    WAKE  = 2'd2
  } type_scr1_cg_state_e;

  localparam logic [3:0] SCR1_CG_IDLE_THR_DFLT = 4'd8;

endpackage : scr1_cg_ctrl_pkg

// File: rtl/scr1_cg.sv
// Glitch-free clock gate primitive.
//   clk       : free-running clock
//   clk_en    : gate enable, may change only while clk is high without effect
//   test_mode : forces the gate open
//   clk_out   : gated clock
module scr1_cg (
  input  logic clk,
  input  logic clk_en,
  input  logic test_mode,
  output logic clk_out
);

  logic en_latched;

  // NOTE: this latch is intentional; it is transparent only while clk is low,
  // so the enable seen by the AND gate is stable for the whole high phase.
  always_latch begin
    if (!clk) begin
      en_latched = clk_en | test_mode;
    end
  end

  assign clk_out = clk & en_latched;

endmodule : scr1_cg

// File: rtl/scr1_cg_ctrl.sv
// Multi-channel clock-gating controller.
// Each channel counts consecutive idle cycles and gates its clock once the
// shared threshold is reached; activity, force or wake request reopens it,
// and a one-cycle wake_ack_o reports the clock running again.
//   clk, rst_n     : core clock, asynchronous active-low reset
//   test_mode      : bypass, all gates open, FSMs held in RUN
//   idle_thr_i     : idle cycles before gating (0 = never gate)
//   ch_busy_i      : per-channel activity
//   ch_force_en_i  : per-channel software force-open
//   wake_req_i     : per-channel level wake request
//   wake_ack_o     : per-channel wake acknowledge pulse
//   ch_clk_en_o    : per-channel registered gate enable
//   ch_gated_o     : per-channel GATED status
//   ch_clk_o       : per-channel gated clock
module scr1_cg_ctrl
  import scr1_cg_ctrl_pkg::*;
#(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned IDLE_CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  test_mode,
  input  logic [IDLE_CNT_W-1:0] idle_thr_i,
  input  logic [CH_NUM-1:0]     ch_busy_i,
  input  logic [CH_NUM-1:0]     ch_force_en_i,
  input  logic [CH_NUM-1:0]     wake_req_i,
  output logic [CH_NUM-1:0]     wake_ack_o,
  output logic [CH_NUM-1:0]     ch_clk_en_o,
  output logic [CH_NUM-1:0]     ch_gated_o,
  output logic [CH_NUM-1:0]     ch_clk_o
);

  localparam logic [IDLE_CNT_W:0] CNT_ONE = {{IDLE_CNT_W{1'b0}}, 1'b1};

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch

    type_scr1_cg_state_e   state_q, state_d;
    logic [IDLE_CNT_W-1:0] cnt_q, cnt_d;
    logic [IDLE_CNT_W:0]   cnt_inc;
    logic                  act;

    assign act     = ch_busy_i[i] | ch_force_en_i[i] | wake_req_i[i];
    // One extra bit so a saturated counter cannot wrap past the threshold.
    assign cnt_inc = {1'b0, cnt_q} + CNT_ONE;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (test_mode) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          RUN: begin
            // Activity takes priority over reaching the threshold.
            if (act || (idle_thr_i == '0)) begin
              cnt_d = '0;
            end else if (cnt_inc >= {1'b0, idle_thr_i}) begin
              state_d = GATED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc[IDLE_CNT_W-1:0];
            end
          end
          GATED: begin
            if (act) state_d = WAKE;
          end
          WAKE: begin
            state_d = RUN;
          end
          default: begin
            state_d = RUN;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // NOTE: state is reset asynchronously so the gate reopens the moment
    // rst_n falls; non-blocking assignments keep all channels sampling the
    // same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= RUN;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Enable derives from the state register, so it changes with the state.
    assign ch_clk_en_o[i] = (state_q != GATED) | test_mode;
    assign ch_gated_o[i]  = (state_q == GATED);
    assign wake_ack_o[i]  = (state_q == WAKE) & ~test_mode;

    scr1_cg u_cg (
      .clk       (clk),
      .clk_en    (ch_clk_en_o[i]),
      .test_mode (test_mode),
      .clk_out   (ch_clk_o[i])
    );

  end : g_ch

endmodule : scr1_cg_ctrl

// File: tb/tb_scr1_cg_ctrl.sv
// Directed self-checking bench for scr1_cg_ctrl (4 channels, 4-bit counter).
module tb_scr1_cg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       test_mode;
  logic [3:0] idle_thr_i;
  logic [3:0] ch_busy_i;
  logic [3:0] ch_force_en_i;
  logic [3:0] wake_req_i;
  logic [3:0] wake_ack_o;
  logic [3:0] ch_clk_en_o;
  logic [3:0] ch_gated_o;
  logic [3:0] ch_clk_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scr1_cg_ctrl #(.CH_NUM(4), .IDLE_CNT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .test_mode     (test_mode),
    .idle_thr_i    (idle_thr_i),
    .ch_busy_i     (ch_busy_i),
    .ch_force_en_i (ch_force_en_i),
    .wake_req_i    (wake_req_i),
    .wake_ack_o    (wake_ack_o),
    .ch_clk_en_o   (ch_clk_en_o),
    .ch_gated_o    (ch_gated_o),
    .ch_clk_o      (ch_clk_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    test_mode     = 1'b0;
    idle_thr_i    = 4'd3;
    ch_busy_i     = '0;
    ch_force_en_i = '0;
    wake_req_i    = '0;
    #12;
    check("rst_en",    ch_clk_en_o, 4'b1111);
    check("rst_gated", ch_gated_o,  4'b0000);
    check("rst_ack",   wake_ack_o,  4'b0000);
    rst_n = 1'b1;

    // Gating latency with threshold 3.
    tick(); check("gate_e1", ch_clk_en_o, 4'b1111);
    tick(); check("gate_e2", ch_clk_en_o, 4'b1111);
    tick(); check("gate_e3", ch_clk_en_o, 4'b0000);
    check("gate_e3_st", ch_gated_o, 4'b1111);

    // Wake channel 2.
    wake_req_i = 4'b0100;
    tick();
    check("wake_en",    ch_clk_en_o, 4'b0100);
    check("wake_ack",   wake_ack_o,  4'b0100);
    check("wake_gated", ch_gated_o,  4'b1011);
    check("wake_clk_n", ch_clk_o,    4'b0000);
    tick();
    check("wake_ack_drop", wake_ack_o, 4'b0000);
    check("wake_clk_n1",   ch_clk_o,   4'b0100);
    check("wake_en_n1",    ch_clk_en_o, 4'b0100);
    wake_req_i = '0;

    // Threshold 5, activity on channel 0 exactly at the gating cycle.
    idle_thr_i = 4'd5;
    reset_pulse();
    repeat (4) tick();
    check("thr5_e4", ch_clk_en_o, 4'b1111);
    ch_busy_i = 4'b0001;
    tick();
    check("thr5_e5_en",    ch_clk_en_o, 4'b0001);
    check("thr5_e5_gated", ch_gated_o,  4'b1110);
    ch_busy_i = '0;
    repeat (4) tick();
    check("thr5_ch0_run", ch_clk_en_o, 4'b0001);
    tick();
    check("thr5_ch0_gate", ch_clk_en_o, 4'b0000);

    // Threshold lowered below the current count.
    idle_thr_i = 4'd10;
    reset_pulse();
    repeat (6) tick();
    check("thr10_e6", ch_clk_en_o, 4'b1111);
    idle_thr_i = 4'd4;
    tick();
    check("thr_low_en",    ch_clk_en_o, 4'b0000);
    check("thr_low_gated", ch_gated_o,  4'b1111);

    // Threshold 0 never gates.
    idle_thr_i = 4'd0;
    reset_pulse();
    for (int k = 0; k < 4; k++) begin
      repeat (5) tick();
      check("thr0_en",    ch_clk_en_o, 4'b1111);
      check("thr0_gated", ch_gated_o,  4'b0000);
    end

    // Test mode while gated.
    idle_thr_i = 4'd2;
    tick();
    tick();
    check("tm_pre_gated", ch_gated_o,  4'b1111);
    check("tm_pre_en",    ch_clk_en_o, 4'b0000);
    test_mode  = 1'b1;
    wake_req_i = 4'b1111;
    #1;
    check("tm_en_comb", ch_clk_en_o, 4'b1111);
    check("tm_ack0",    wake_ack_o,  4'b0000);
    tick();
    check("tm_ack1",   wake_ack_o,  4'b0000);
    check("tm_gated1", ch_gated_o,  4'b0000);
    check("tm_clk",    ch_clk_o,    4'b1111);
    tick();
    check("tm_ack2", wake_ack_o, 4'b0000);
    test_mode  = 1'b0;
    wake_req_i = '0;
    tick();
    check("tm_rel_e1", ch_clk_en_o, 4'b1111);
    tick();
    check("tm_rel_e2", ch_clk_en_o, 4'b0000);

    // Reset asserted while in WAKE.
    wake_req_i = 4'b1111;
    tick();
    check("rw_ack", wake_ack_o, 4'b1111);
    check("rw_clk", ch_clk_o,   4'b0000);
    #1;
    rst_n = 1'b0;
    #1;
    check("rw_rst_ack",   wake_ack_o,  4'b0000);
    check("rw_rst_en",    ch_clk_en_o, 4'b1111);
    check("rw_rst_gated", ch_gated_o,  4'b0000);
    check("rw_rst_clk",   ch_clk_o,    4'b0000);
    wake_req_i = '0;
    tick();
    check("rw_clk_next", ch_clk_o, 4'b1111);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_scr1_cg_ctrl
